// File: rtl/booth_mult.sv
// Sequential signed multiplier using radix-2 Booth recoding.
// One Booth iteration per clock; the 2*WIDTH-bit product is split into hi/lo.
// The control unit uses the start/busy/done handshake to stall on the MULT path.
module booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  // A and M carry one guard bit so that subtracting the most-negative M cannot overflow.
  logic [WIDTH:0]   a_r, a_s;
  logic [WIDTH:0]   m_r, m_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic             q1_r, q1_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] hi_s, lo_s;
  logic             busy_s, done_s;
  logic [2*WIDTH+1:0] step_s;

  // One Booth iteration: add/subtract M depending on {Q[0],Q-1}, then
  // arithmetic-shift {A,Q,Q-1} right by one. Result packs {A',Q',Q-1'}.
  function automatic logic [2*WIDTH+1:0] booth_step(
    input logic [WIDTH:0]   a,
    input logic [WIDTH:0]   m,
    input logic [WIDTH-1:0] q,
    input logic             q1
  );
    logic [WIDTH:0] sum;
    case ({q[0], q1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    // Shifting right drops the old Q-1; the old Q[0] becomes the new Q-1.
    return {sum[WIDTH], sum, q};
  endfunction

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    m_s     = m_r;
    q_s     = q_r;
    q1_s    = q1_r;
    cnt_s   = cnt_r;
    hi_s    = hi;
    lo_s    = lo;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    step_s  = booth_step(a_r, m_r, q_r, q1_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          m_s     = {data_a[WIDTH-1], data_a};
          q_s     = data_b;
          a_s     = '0;
          q1_s    = 1'b0;
          cnt_s   = CW'(WIDTH);
          state_s = RUN;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        busy_s = 1'b1;
        a_s    = step_s[2*WIDTH+1:WIDTH+1];
        q_s    = step_s[WIDTH:1];
        q1_s   = step_s[0];
        cnt_s  = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          hi_s    = step_s[2*WIDTH:WIDTH+1];
          lo_s    = step_s[WIDTH:1];
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      a_r     <= '0;
      m_r     <= '0;
      q_r     <= '0;
      q1_r    <= 1'b0;
      cnt_r   <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      m_r     <= m_s;
      q_r     <= q_s;
      q1_r    <= q1_s;
      cnt_r   <= cnt_s;
      hi      <= hi_s;
      lo      <= lo_s;
      busy    <= busy_s;
      done    <= done_s;
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// Directed self-checking bench for booth_mult (WIDTH=32).
module tb_booth_mult;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total;
  int bad;

  booth_mult #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data_a (data_a),
    .data_b (data_b),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one multiply and follow it to completion.
  // disturb=1: pulse start with other operands at cycle 10 and scramble operands at cycle 11.
  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit disturb);
    int done_cyc;
    int done_cnt;
    done_cyc = -1;
    done_cnt = 0;
    @(negedge clk);
    data_a = a;
    data_b = b;
    start  = 1'b1;
    @(posedge clk);               // edge E0
    @(negedge clk);
    start  = 1'b0;
    data_a = 32'hDEAD_BEEF;       // operands must have been captured already
    data_b = 32'h1234_5678;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end else if (cyc < 32) begin
        check({tag, " busy_in_run"}, {63'd0, busy}, 64'd1);
      end
      if (disturb && cyc == 10) begin
        data_a = 32'd9;
        data_b = 32'd9;
        start  = 1'b1;
      end
      if (disturb && cyc == 11) begin
        start  = 1'b0;
        data_a = 32'h8000_0000;
        data_b = 32'hFFFF_FFFF;
      end
      if (cyc == 32) begin
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
      end
      if (cyc == 33) begin
        check({tag, " done_one_cycle"}, {63'd0, done}, 64'd0);
      end
    end
    check({tag, " done_cycle"}, 64'(done_cyc), 64'd32);
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " hi_held"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo_held"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    int done_seen;
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    start  = 1'b0;
    data_a = 32'd0;
    data_b = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    reset = 1'b0;

    run_mult("3x5",     32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F, 1'b0);
    run_mult("m3x5",    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_mult("m1xm1",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001, 1'b0);
    run_mult("minxmin", 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0);
    run_mult("maxxmax", 32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h3FFF_FFFF, 32'h0000_0001, 1'b0);
    run_mult("minxmax", 32'h8000_0000,  32'h7FFF_FFFF,  32'hC000_0000, 32'h8000_0000, 1'b0);
    run_mult("6x7_dist", 32'd6,         32'd7,          32'h0000_0000, 32'h0000_002A, 1'b1);

    // Reset in the middle of an operation
    @(negedge clk);
    data_a = 32'd6;
    data_b = 32'd7;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("midrst busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst hi", {32'd0, hi}, 64'd0);
    check("midrst lo", {32'd0, lo}, 64'd0);
    check("midrst busy", {63'd0, busy}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("midrst no_done", 64'(done_seen), 64'd0);

    run_mult("2x2_after_rst", 32'd2, 32'd2, 32'h0000_0000, 32'h0000_0004, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
